dm_ext: RTL and testbench
=========================

# dm_ext

Parametrised data memory for the MIPS pipeline's MEM stage. It supports byte, halfword and word access, with sign or zero extension on loads. A req/ready handshake adds a configurable number of wait states, and the block flags misaligned accesses. It is the next-generation replacement for the single-cycle word-only data memory. The stall logic uses `busy` to freeze the pipeline while an access is in flight.

## Interface
- ADDR_WIDTH, 12: word-index width; depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0: extra wait states per access, range 0..15.
- TRACE, 1: when 1, write-commit trace lines are printed.

- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  access request, sampled when busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- pc  in  32  PC of the issuing instruction; used only for the trace.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- busy  out  1  high while an access is in flight; req is ignored while high.
- ready  out  1  one-cycle pulse marking access completion.
- rdata  out  32  extended load result; valid while ready=1.
- addr_err  out  1  valid with ready: access was misaligned or reserved.

## Operation
- FSM states: IDLE, WAIT, RESP.
- busy = (state != IDLE).
- ready = (state == RESP).
- IDLE, req=1:
  - Latch we, size, sign_ext, pc, addr, wdata.
  - Go to WAIT with cnt = WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go to RESP.
- WAIT: decrement cnt; go to RESP when cnt == 0.
- RESP: go to IDLE unconditionally. A new request can therefore be accepted no earlier than the cycle after ready.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 4·2^ADDR_WIDTH. Aliasing is not an error.
- Byte lane k = addr[1:0] maps to bits [8k+7:8k] (little-endian).
- Halfword lanes: addr[1]=0 maps to [15:0], addr[1]=1 maps to [31:16].
- Misaligned / error conditions:
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]≠0.
  - size=11.
- On an error: addr_err=1, rdata=0, memory unchanged, no trace line.
- Store: only the addressed lanes are modified; the other lanes keep their old value.
  - sb writes wdata[7:0].
  - sh writes wdata[15:0].
  - sw writes all 32 bits.
- Load: extract the addressed byte or half, then extend according to sign_ext. A word load ignores sign_ext.
- Trace: when TRACE=1, print on every successful store commit:
  - Format: "%d@%h: *%h <= %h".
  - Fields: $time, latched pc, word-aligned address {addr[31:2],2'b00}, full merged 32-bit word after the write.
  - Skip the line if wdata contains X.
- Memory is zero-initialised at time 0.

## Timing
- Acceptance happens at the posedge where state=IDLE and req=1.
- Load or store commit occurs at the posedge that enters RESP. At that edge rdata and addr_err are registered and the memory write is performed.
- Latency from the acceptance edge to the first cycle with ready=1 is 1+WAIT_CYCLES cycles.
- busy rises in the cycle after acceptance and stays high through the RESP cycle.
- ready is high for exactly 1 cycle.
- A load in RESP returns data as stored before any later access. A load issued right after a store to the same word sees the new data, with no forwarding hazard.
- Outside RESP, rdata and addr_err hold their last values. Consumers sample them only while ready=1.
- reset (any state, including mid-access):
  - Next state is IDLE; cnt = 0.
  - busy = 0, ready = 0, rdata = 0, addr_err = 0.
  - Every memory word is cleared to 0.
  - An in-flight store is discarded: no write and no trace line.
- req held high across completion:
  - The same request is re-accepted in the IDLE cycle after RESP.
  - The MEM stage deasserts req on ready.

## Test plan
- WAIT_CYCLES=0:
  - sw 0x12345678 at 0x100, then lw 0x100 → ready 1 cycle after each acceptance; rdata = 0x12345678.
  - Trace line "*00000100 <= 12345678".
- Byte lanes:
  - After the word above, sb 0xAB at 0x102 → word = 0x12AB5678.
  - lb 0x102 → 0xFFFFFFAB; lbu 0x102 → 0x000000AB.
  - lh 0x102 → 0x000012AB.
- WAIT_CYCLES=3:
  - lw accepted at edge T → busy high for cycles T+1..T+4; ready only at T+4.
  - req pulses during busy are ignored: exactly one ready per accepted request.
- Misaligned accesses:
  - sh at 0x101 and sw at 0x102 → addr_err=1, rdata=0; memory word 0x100 unchanged; no trace line.
  - size=11 → addr_err=1.
- Reset mid-access:
  - With WAIT_CYCLES=2, assert reset 1 cycle after accepting sw 0xDEADBEEF at 0x8.
  - → busy, ready, rdata = 0 next cycle; later lw 0x8 → 0; no trace line.
- Aliasing with ADDR_WIDTH=4:
  - sw 0x5 at 0x40, then lw 0x0 → 0x00000005.

Source files
------------

// File: rtl/dm_ext.sv
// dm_ext: MEM-stage data memory with byte/half/word access, load extension,
// req/ready handshake with configurable wait states and misalignment flagging.
module dm_ext #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0,
  parameter bit TRACE       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;

  // Request fields captured at acceptance
  logic        we_p0;
  logic        sign_ext_p0;
  logic [1:0]  size_p0;
  logic [31:0] pc_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic [31:0] mem [DEPTH];

  // Effective access: live inputs in IDLE (zero-wait commit), latched copy otherwise
  logic                  acc_we;
  logic                  acc_sx;
  logic [1:0]            acc_size;
  logic [31:0]           acc_pc;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic [31:0]           load_word;
  logic                  acc_err;
  logic                  accept;
  logic                  commit;

  // Reserved size, odd halfword and non-word-aligned word are all errors.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    logic bad;
    case (sz)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Bit mask of the lanes touched by an access of the given size.
  function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    case (sz)
      2'b00:   m = 32'h0000_00FF << {lane, 3'b000};
      2'b01:   m = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Merge right-aligned store data into the old word; untouched lanes survive.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] rep;
    logic [31:0] m;
    m = lane_mask(sz, lane);
    case (sz)
      2'b00:   rep = {4{wd[7:0]}};
      2'b01:   rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    return (old & ~m) | (rep & m);
  endfunction

  // Extract the addressed byte/half and extend it; word loads pass through.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic sx);
    logic        [7:0]  b_u;
    logic        [15:0] h_u;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    logic        [31:0] res;
    b_u = word[{lane, 3'b000} +: 8];
    h_u = lane[1] ? word[31:16] : word[15:0];
    b_s = signed'(b_u);
    h_s = signed'(h_u);
    case (sz)
      2'b00: begin
        ext_s = b_s;
        res   = sx ? ext_s : {24'd0, b_u};
      end
      2'b01: begin
        ext_s = h_s;
        res   = sx ? ext_s : {16'd0, h_u};
      end
      default: begin
        ext_s = '0;
        res   = word;
      end
    endcase
    return res;
  endfunction

  assign busy  = (state != IDLE);
  assign ready = (state == RESP);

  // Select the access view and compute error, merged store word and load result
  always_comb begin
    if (state == IDLE) begin
      acc_we    = we;
      acc_sx    = sign_ext;
      acc_size  = size;
      acc_pc    = pc;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_we    = we_p0;
      acc_sx    = sign_ext_p0;
      acc_size  = size_p0;
      acc_pc    = pc_p0;
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
    end
    acc_idx     = acc_addr[ADDR_WIDTH+1:2];
    old_word    = mem[acc_idx];
    acc_err     = is_misaligned(acc_size, acc_addr[1:0]);
    merged_word = store_merge(old_word, acc_wdata, acc_size, acc_addr[1:0]);
    load_word   = load_extend(old_word, acc_size, acc_addr[1:0], acc_sx);
    accept      = (state == IDLE) && req;
    commit      = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
  end

  // Next-state logic for the IDLE -> WAIT -> RESP handshake
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture the request at acceptance; payload needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0       <= we;
      sign_ext_p0 <= sign_ext;
      size_p0     <= size;
      pc_p0       <= pc;
      addr_p0     <= addr;
      wdata_p0    <= wdata;
    end
  end

  // Register the response at the edge entering RESP; hold it otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= 32'd0;
      addr_err <= 1'b0;
    end else if (commit) begin
      addr_err <= acc_err;
      rdata    <= (acc_err || acc_we) ? 32'd0 : load_word;
    end
  end

  // Memory array: cleared on reset, written only by a clean store commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (commit && acc_we && !acc_err) begin
      mem[acc_idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  generate
    if (TRACE) begin : g_trace
      // Simulation trace of every committed store with the merged word
      always @(posedge clk) begin
        if (!reset && commit && acc_we && !acc_err && !$isunknown(acc_wdata)) begin
          $write("%d@%h: *%h <= %h\n", $time, acc_pc, {acc_addr[31:2], 2'b00}, merged_word);
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: randomized and directed checks of dm_ext against a byte-level
// reference memory, across three parameterisations.
module tb_dm_ext;

  localparam int NI = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NI-1:0]  req;
  logic           we;
  logic [1:0]     size;
  logic           sign_ext;
  logic [31:0]    pc;
  logic [31:0]    addr;
  logic [31:0]    wdata;
  logic [NI-1:0]  busy;
  logic [NI-1:0]  ready;
  logic [NI-1:0]  addr_err;
  logic [31:0]    rdata [NI];

  int n_cmp = 0;
  int n_mis = 0;

  // Reference memory: byte address (per instance) -> byte; absent means zero
  logic [7:0] mref [int];

  dm_ext #(.ADDR_WIDTH(12), .WAIT_CYCLES(0), .TRACE(1'b1)) u_w0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we), .size(size), .sign_ext(sign_ext),
    .pc(pc), .addr(addr), .wdata(wdata), .busy(busy[0]), .ready(ready[0]),
    .rdata(rdata[0]), .addr_err(addr_err[0]));

  dm_ext #(.ADDR_WIDTH(12), .WAIT_CYCLES(3), .TRACE(1'b1)) u_w3 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we), .size(size), .sign_ext(sign_ext),
    .pc(pc), .addr(addr), .wdata(wdata), .busy(busy[1]), .ready(ready[1]),
    .rdata(rdata[1]), .addr_err(addr_err[1]));

  dm_ext #(.ADDR_WIDTH(4), .WAIT_CYCLES(2), .TRACE(1'b1)) u_a4 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we), .size(size), .sign_ext(sign_ext),
    .pc(pc), .addr(addr), .wdata(wdata), .busy(busy[2]), .ready(ready[2]),
    .rdata(rdata[2]), .addr_err(addr_err[2]));

  always #5 clk = ~clk;

  function automatic int aw_of(input int s);
    return (s == 2) ? 4 : 12;
  endfunction

  function automatic int wc_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bkey(input int s, input logic [31:0] a);
    logic [31:0] msz;
    msz = 32'd4 << aw_of(s);
    return s * 65536 + int'(a & (msz - 32'd1));
  endfunction

  // Behavioural access: byte-granular memory, aliasing by modulo
  function automatic void ref_access(input int s, input bit w, input logic [1:0] sz,
                                     input bit sx, input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic err);
    int nb;
    int k;
    logic [31:0] v;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd  = 32'd0;
    if (err) return;
    nb = 1 << sz;
    if (w) begin
      for (int i = 0; i < nb; i++) mref[bkey(s, a + 32'(i))] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) begin
        k = bkey(s, a + 32'(i));
        if (mref.exists(k)) v[8*i +: 8] = mref[k];
      end
      if (nb < 4 && sx && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end
  endfunction

  task automatic run(input int s, input bit w, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [31:0] wd, input string tag,
                     output logic [31:0] rd);
    logic [31:0] erd;
    logic        eerr;
    int          lat;
    ref_access(s, w, sz, sx, a, wd, erd, eerr);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; pc = $urandom; req[s] = 1'b1;
    @(posedge clk);
    #1 req[s] = 1'b0;
    lat = 1;
    while (!ready[s] && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(wc_of(s) + 1));
    chk({tag, "_rd"}, rdata[s], erd);
    chk({tag, "_err"}, 32'(addr_err[s]), 32'(eerr));
    rd = rdata[s];
    @(posedge clk);
    #1 chk({tag, "_rdy1"}, 32'(ready[s]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] a;
    logic [1:0]  sz;
    int          nrdy;
    int          r;

    reset = 1'b1; req = '0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
    pc = 32'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < NI; s++) begin
      chk($sformatf("rst_busy%0d", s), 32'(busy[s]), 32'd0);
      chk($sformatf("rst_ready%0d", s), 32'(ready[s]), 32'd0);
      chk($sformatf("rst_rdata%0d", s), rdata[s], 32'd0);
      chk($sformatf("rst_err%0d", s), 32'(addr_err[s]), 32'd0);
    end
    @(negedge clk) reset = 1'b0;

    // Zero-wait word, byte lanes and extension
    run(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, "sw100", rd);
    run(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "lw100", rd);
    chk("lw100_k", rd, 32'h1234_5678);
    run(0, 1'b1, 2'd0, 1'b0, 32'h102, 32'hFFFF_FFAB, "sb102", rd);
    run(0, 1'b0, 2'd2, 1'b1, 32'h100, 32'h0, "lw_merge", rd);
    chk("lw_merge_k", rd, 32'h12AB_5678);
    run(0, 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, "lb102", rd);
    chk("lb102_k", rd, 32'hFFFF_FFAB);
    run(0, 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, "lbu102", rd);
    chk("lbu102_k", rd, 32'h0000_00AB);
    run(0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, "lh102", rd);
    chk("lh102_k", rd, 32'h0000_12AB);

    // Misaligned and reserved accesses leave memory alone
    run(0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h0000_FFFF, "sh101", rd);
    run(0, 1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFF_FFFF, "sw102", rd);
    run(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, "rsv_ld", rd);
    run(0, 1'b1, 2'd3, 1'b0, 32'h100, 32'h0, "rsv_st", rd);
    run(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "lw_after_err", rd);
    chk("lw_after_err_k", rd, 32'h12AB_5678);

    // Three wait states: busy window, single ready, req pulses ignored
    run(1, 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFE_F00D, "sw200_w3", rd);
    ref_access(1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, erd, eerr);
    @(negedge clk);
    we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h200; req[1] = 1'b1;
    @(posedge clk);
    nrdy = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("w3_busy%0d", k), 32'(busy[1]), 32'd1);
      chk($sformatf("w3_ready%0d", k), 32'(ready[1]), 32'(k == 4));
      if (ready[1]) begin
        nrdy++;
        chk("w3_rd", rdata[1], erd);
        chk("w3_rd_k", rdata[1], 32'hCAFE_F00D);
      end
      @(negedge clk) req[1] = (k < 4) ? 1'($urandom % 2) : 1'b0;
      @(posedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("w3_idle%0d", j), 32'(busy[1]), 32'd0);
      if (ready[1]) nrdy++;
      @(posedge clk);
    end
    chk("w3_nready", 32'(nrdy), 32'd1);

    // Reset one cycle after accepting a store discards it and clears memory
    run(2, 1'b1, 2'd2, 1'b0, 32'hC, 32'h11, "swC", rd);
    run(2, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0, "lwC", rd);
    chk("lwC_k", rd, 32'h11);
    @(negedge clk);
    we = 1'b1; size = 2'd2; addr = 32'h8; wdata = 32'hDEAD_BEEF; req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    chk("mid_busy_pre", 32'(busy[2]), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy[2]), 32'd0);
    chk("mid_ready", 32'(ready[2]), 32'd0);
    chk("mid_rdata", rdata[2], 32'd0);
    chk("mid_err", 32'(addr_err[2]), 32'd0);
    @(negedge clk) reset = 1'b0;
    mref.delete();
    run(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "lw8_rst", rd);
    chk("lw8_rst_k", rd, 32'd0);
    run(2, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0, "lwC_rst", rd);
    chk("lwC_rst_k", rd, 32'd0);
    run(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "lw100_rst", rd);
    chk("lw100_rst_k", rd, 32'd0);

    // Aliasing on the 16-word instance
    run(2, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5, "sw40", rd);
    run(2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw0_alias", rd);
    chk("lw0_alias_k", rd, 32'h0000_0005);

    // Randomized mix of loads/stores, sizes, extension and aliased addresses
    for (int s = 0; s < NI; s++) begin
      for (int it = 0; it < 80; it++) begin
        r  = int'($urandom % 8);
        sz = (r < 7) ? 2'(r % 3) : 2'd3;
        a  = ($urandom % 4) * 32'h4000 + ($urandom % 64);
        if (($urandom % 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
        run(s, 1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
            $sformatf("rnd%0d_%0d", s, it), rd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
